// File: rtl/crossbar_slave_arbiter_pkg.sv
// Shared types for the crossbar slave-port arbiter: FSM states, master ids and width defaults.
package crossbar_slave_arbiter_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    M1 = 1'b0,
    M2 = 1'b1
  } master_t;

  function automatic master_t other_master(input master_t m);
    return (m == M1) ? M2 : M1;
  endfunction

endpackage

// File: rtl/crossbar_slave_arbiter_rr.sv
// Combinational 2-way round-robin grant: a lone requester wins, on a tie the
// master that did not win last time is chosen.
module crossbar_slave_arbiter_rr
  import crossbar_slave_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_t    last_grant_i,
  output logic       grant_valid_o,
  output master_t    grant_o
);

  always_comb begin
    grant_valid_o = |req_i;
    grant_o       = M1;
    case (req_i)
      2'b01:   grant_o = M1;
      2'b10:   grant_o = M2;
      2'b11:   grant_o = other_master(last_grant_i);
      default: grant_o = M1;
    endcase
  end

endmodule

// File: rtl/crossbar_slave_arbiter.sv
// One slave port of the 2x2 crossbar: arbitrates the two masters, issues a single
// memory request, returns ack/err plus read data to the granted master only.
module crossbar_slave_arbiter
  import crossbar_slave_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_1m,
  input  logic                  cmd_1m,
  input  logic [ADDR_WIDTH-1:0] addr_1m,
  input  logic [DATA_WIDTH-1:0] wdata_1m,
  output logic                  ack_1m,
  output logic                  err_1m,
  output logic [DATA_WIDTH-1:0] rdata_1m,
  input  logic                  req_2m,
  input  logic                  cmd_2m,
  input  logic [ADDR_WIDTH-1:0] addr_2m,
  input  logic [DATA_WIDTH-1:0] wdata_2m,
  output logic                  ack_2m,
  output logic                  err_2m,
  output logic [DATA_WIDTH-1:0] rdata_2m,
  output logic                  mem_req,
  output logic                  mem_cmd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int WDOG_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);

  state_t                  state_q;
  master_t                 grant_q;
  master_t                 last_grant_q;
  logic [WDOG_W-1:0]       wdog_q;
  logic [WDOG_W-1:0]       wdog_d;
  logic                    mem_req_q;
  logic                    mem_cmd_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic                    ack_1m_q;
  logic                    err_1m_q;
  logic                    ack_2m_q;
  logic                    err_2m_q;
  logic [DATA_WIDTH-1:0]   rdata_1m_q;
  logic [DATA_WIDTH-1:0]   rdata_2m_q;
  logic [DATA_WIDTH-1:0]   resp_data_d;
  logic                    grant_valid;
  master_t                 grant_id;

  crossbar_slave_arbiter_rr u_rr (
    .req_i         ({req_2m, req_1m}),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant_id)
  );

  assign wdog_d = wdog_q + 1'b1;
  // Writes and aborts return zero data; only an acked read forwards the slave data.
  assign resp_data_d = (mem_ack && !mem_cmd_q) ? mem_rdata : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= M1;
      last_grant_q <= M2;
      wdog_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_cmd_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ack_1m_q     <= 1'b0;
      err_1m_q     <= 1'b0;
      ack_2m_q     <= 1'b0;
      err_2m_q     <= 1'b0;
      rdata_1m_q   <= '0;
      rdata_2m_q   <= '0;
    end else begin
      ack_1m_q   <= 1'b0;
      err_1m_q   <= 1'b0;
      ack_2m_q   <= 1'b0;
      err_2m_q   <= 1'b0;
      rdata_1m_q <= '0;
      rdata_2m_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            state_q     <= ST_ISSUE;
            grant_q     <= grant_id;
            wdog_q      <= '0;
            mem_req_q   <= 1'b1;
            mem_cmd_q   <= (grant_id == M1) ? cmd_1m : cmd_2m;
            mem_addr_q  <= (grant_id == M1) ? addr_1m : addr_2m;
            mem_wdata_q <= (grant_id == M1) ? wdata_1m : wdata_2m;
          end
        end
        ST_ISSUE: begin
          // An ack arriving on the watchdog limit cycle still counts as a normal completion.
          if (mem_ack || (wdog_q == WDOG_LIMIT)) begin
            state_q     <= ST_RESP;
            mem_req_q   <= 1'b0;
            mem_cmd_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if (grant_q == M1) begin
              ack_1m_q   <= mem_ack;
              err_1m_q   <= !mem_ack;
              rdata_1m_q <= resp_data_d;
            end else begin
              ack_2m_q   <= mem_ack;
              err_2m_q   <= !mem_ack;
              rdata_2m_q <= resp_data_d;
            end
          end else begin
            wdog_q <= wdog_d;
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          last_grant_q <= grant_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_cmd   = mem_cmd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ack_1m    = ack_1m_q;
  assign err_1m    = err_1m_q;
  assign rdata_1m  = rdata_1m_q;
  assign ack_2m    = ack_2m_q;
  assign err_2m    = err_2m_q;
  assign rdata_2m  = rdata_2m_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crossbar_slave_arbiter.sv
// Scoreboard bench: drivers push expected memory-side and master-side responses,
// a monitor pops and compares them whenever the DUT issues or completes.
module tb_crossbar_slave_arbiter;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_1m = 1'b0, cmd_1m = 1'b0, req_2m = 1'b0, cmd_2m = 1'b0;
  logic [15:0] addr_1m = '0, addr_2m = '0;
  logic [31:0] wdata_1m = '0, wdata_2m = '0;
  logic        ack_1m, err_1m, ack_2m, err_2m;
  logic [31:0] rdata_1m, rdata_2m;
  logic        mem_req, mem_cmd, busy;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  crossbar_slave_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_1m(req_1m), .cmd_1m(cmd_1m), .addr_1m(addr_1m), .wdata_1m(wdata_1m),
    .ack_1m(ack_1m), .err_1m(err_1m), .rdata_1m(rdata_1m),
    .req_2m(req_2m), .cmd_2m(cmd_2m), .addr_2m(addr_2m), .wdata_2m(wdata_2m),
    .ack_2m(ack_2m), .err_2m(err_2m), .rdata_2m(rdata_2m),
    .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        cmd;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          kind;     // 0: issue one cycle after req, 1: issue two cycles after previous response
    int          req_cyc;
  } mem_exp_t;

  typedef struct {
    int          master;
    bit          is_err;
    logic [31:0] rdata;
    int          lat;      // slave ack latency in ISSUE cycles, 0 = never acks
  } resp_exp_t;

  mem_exp_t    mem_q[$];
  resp_exp_t   resp_q[$];
  int          lat_q[$];
  logic [31:0] ref_mem[16];
  logic [31:0] slv_mem[16];
  int          lg_model = 2;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference: expected issue/response for one granted transaction, in grant order.
  task automatic push_txn(input int m, input bit c, input logic [15:0] a,
                          input logic [31:0] w, input int lat, input int kind);
    resp_exp_t r;
    mem_q.push_back('{c, a, w, kind, cyc});
    lat_q.push_back(lat);
    r.master = m;
    r.lat    = lat;
    r.is_err = (lat == 0);
    r.rdata  = '0;
    if (lat != 0) begin
      if (c) ref_mem[a[4:1]] = w;
      else   r.rdata = ref_mem[a[4:1]];
    end
    resp_q.push_back(r);
    lg_model = m;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((busy || mem_req) && n < 100);
    if (n >= 100) begin
      errors++;
      $display("FAIL idle_wait: busy=%0b after %0d cycles required 0", busy, n);
    end
  endtask

  task automatic wait_done(input bit need1, input bit need2, input bit scramble);
    bit d1 = !need1;
    bit d2 = !need2;
    bit scr = 1'b0;
    int n = 0;
    while (!(d1 && d2)) begin
      @(negedge clock);
      n++;
      if (ack_1m || err_1m) begin req_1m = 1'b0; d1 = 1'b1; end
      if (ack_2m || err_2m) begin req_2m = 1'b0; d2 = 1'b1; end
      if (scramble && !scr && mem_req) begin
        scr = 1'b1;
        if (need1) begin
          req_1m = 1'b0; cmd_1m = ~cmd_1m; addr_1m = 16'($urandom); wdata_1m = $urandom;
        end else begin
          req_2m = 1'b0; cmd_2m = ~cmd_2m; addr_2m = 16'($urandom); wdata_2m = $urandom;
        end
      end
      if (n > 400) begin
        errors++;
        $display("FAIL txn_wait: done=%0b%0b after %0d cycles required 11", d2, d1, n);
        req_1m = 1'b0; req_2m = 1'b0;
        mem_q.delete(); resp_q.delete(); lat_q.delete();
        break;
      end
    end
  endtask

  // sel: 1 = M1 only, 2 = M2 only, 3 = both.
  task automatic do_txn(input int sel,
                        input bit c1, input logic [15:0] a1, input logic [31:0] w1, input int l1,
                        input bit c2, input logic [15:0] a2, input logic [31:0] w2, input int l2,
                        input bit scramble);
    wait_idle();
    if (sel == 3) begin
      if (lg_model == 2) begin
        push_txn(1, c1, a1, w1, l1, 0);
        push_txn(2, c2, a2, w2, l2, 1);
      end else begin
        push_txn(2, c2, a2, w2, l2, 0);
        push_txn(1, c1, a1, w1, l1, 1);
      end
    end else if (sel == 1) begin
      push_txn(1, c1, a1, w1, l1, 0);
    end else begin
      push_txn(2, c2, a2, w2, l2, 0);
    end
    if (sel != 2) begin req_1m = 1'b1; cmd_1m = c1; addr_1m = a1; wdata_1m = w1; end
    if (sel != 1) begin req_2m = 1'b1; cmd_2m = c2; addr_2m = a2; wdata_2m = w2; end
    $display("txn sel=%0d m1:cmd=%0b addr=%04h lat=%0d m2:cmd=%0b addr=%04h lat=%0d scr=%0b",
             sel, c1, a1, l1, c2, a2, l2, scramble);
    wait_done(sel != 2, sel != 1, scramble);
  endtask

  // Slave model: acks on the lat-th ISSUE cycle, and toggles mem_ack randomly outside ISSUE.
  initial begin : slave
    bit s_prev = 1'b0;
    int s_cnt = 0;
    int s_lat = 0;
    forever begin
      @(negedge clock);
      if (mem_req === 1'b1) begin
        if (!s_prev) begin
          s_cnt = 1;
          s_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        end else begin
          s_cnt++;
        end
        if (s_lat != 0 && s_cnt == s_lat) begin
          mem_ack = 1'b1;
          if (mem_cmd) begin
            slv_mem[mem_addr[4:1]] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = slv_mem[mem_addr[4:1]];
          end
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end
        s_prev = 1'b1;
      end else begin
        s_prev = 1'b0;
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  initial begin : monitor
    bit        prev = 1'b0;
    int        rise_cyc = 0;
    int        last_resp_cyc = 0;
    mem_exp_t  cur;
    resp_exp_t r;
    int        got_m;
    wait (mon_en);
    forever begin
      @(negedge clock);
      chk("busy_vs_activity", {62'd0, busy}, {63'd0, mem_req | ack_1m | err_1m | ack_2m | err_2m});
      chk("pulse_exclusive", {62'd0, (ack_1m | err_1m) & (ack_2m | err_2m), (ack_1m & err_1m) | (ack_2m & err_2m)}, 64'd0);
      chk("rdata_idle_zero", {ack_1m ? 32'd0 : rdata_1m, ack_2m ? 32'd0 : rdata_2m}, 64'd0);
      if (mem_req && !prev) begin
        rise_cyc = cyc;
        if (mem_q.size() == 0) begin
          chk("unexpected_issue", 64'd1, 64'd0);
        end else begin
          cur = mem_q.pop_front();
          chk("issue_fields", {15'd0, mem_cmd, mem_addr, mem_wdata}, {15'd0, cur.cmd, cur.addr, cur.wdata});
          chk("issue_cycle", 64'(cyc), 64'((cur.kind == 0) ? cur.req_cyc + 1 : last_resp_cyc + 2));
        end
      end else if (mem_req && prev) begin
        chk("issue_hold", {15'd0, mem_cmd, mem_addr, mem_wdata}, {15'd0, cur.cmd, cur.addr, cur.wdata});
      end
      if (ack_1m || err_1m || ack_2m || err_2m) begin
        last_resp_cyc = cyc;
        if (resp_q.size() == 0) begin
          chk("unexpected_response", 64'd1, 64'd0);
        end else begin
          r = resp_q.pop_front();
          got_m = (ack_1m || err_1m) ? 1 : 2;
          chk("resp_master", 64'(got_m), 64'(r.master));
          chk("resp_is_err", {63'd0, err_1m | err_2m}, {63'd0, r.is_err});
          chk("resp_rdata", {32'd0, (got_m == 1) ? rdata_1m : rdata_2m}, {32'd0, r.rdata});
          chk("resp_latency", 64'(cyc - rise_cyc), 64'((r.lat == 0) ? TIMEOUT + 1 : r.lat));
        end
      end
      prev = mem_req;
    end
  end

  initial begin : stim
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[0] = 32'h12345678;
    slv_mem[0] = 32'h12345678;

    // Reset held for two edges; everything must be quiet.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ctrl", {57'd0, busy, mem_req, mem_cmd, ack_1m, err_1m, ack_2m, err_2m}, 64'd0);
    chk("rst_addr_wdata", {16'd0, mem_addr, mem_wdata}, 64'd0);
    chk("rst_rdata", {rdata_1m, rdata_2m}, 64'd0);
    reset = 1'b1;
    mon_en = 1'b1;

    // Directed scenarios.
    do_txn(1, 1'b1, 16'h0010, 32'hDEADBEEF, 1, 1'b0, 16'h0, 32'h0, 1, 1'b0);
    do_txn(2, 1'b0, 16'h0, 32'h0, 1, 1'b0, 16'h0200, 32'h0, 3, 1'b0);
    do_txn(3, 1'b0, 16'h0010, 32'h0, 2, 1'b1, 16'h0012, 32'hA5A5A5A5, 1, 1'b0);
    do_txn(3, 1'b1, 16'h0014, 32'h01020304, 1, 1'b0, 16'h0014, 32'h0, 2, 1'b0);
    do_txn(1, 1'b0, 16'h0030, 32'h0, 0, 1'b0, 16'h0, 32'h0, 1, 1'b0);
    do_txn(1, 1'b0, 16'h0030, 32'h0, 2, 1'b0, 16'h0, 32'h0, 1, 1'b0);

    // Reset during ISSUE: nothing completes, then the same request goes through.
    wait_idle();
    mem_q.push_back('{1'b0, 16'h0044, 32'h0, 0, cyc});
    lat_q.push_back(0);
    req_1m = 1'b1; cmd_1m = 1'b0; addr_1m = 16'h0044; wdata_1m = 32'h0;
    while (!mem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rstmid_idle", {61'd0, mem_req, busy, ack_1m | err_1m}, 64'd0);
    $display("txn reset during ISSUE, mem_req=%0b busy=%0b", mem_req, busy);
    reset = 1'b1;
    lg_model = 2;
    push_txn(1, 1'b0, 16'h0044, 32'h0, 2, 0);
    wait_done(1'b1, 1'b0, 1'b0);

    // Inputs changed and req dropped mid-ISSUE.
    do_txn(1, 1'b0, 16'h0050, 32'h0, 4, 1'b0, 16'h0, 32'h0, 1, 1'b1);
    do_txn(2, 1'b0, 16'h0, 32'h0, 1, 1'b1, 16'h0056, 32'hCAFEF00D, 3, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 120; i++) begin
      int  sel = $urandom_range(1, 3);
      bit  scr = (sel != 3) && ($urandom_range(0, 2) == 0);
      int  l1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
      int  l2 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_txn(sel, 1'($urandom), 16'($urandom), $urandom, l1,
                  1'($urandom), 16'($urandom), $urandom, l2, scr);
    end

    repeat (5) @(negedge clock);
    chk("queues_drained", 64'(mem_q.size() + resp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
